// File: rtl/alu_exec_unit.sv
// alu_exec_unit: single-cycle ALU feeding an exec register (E) and a result
// FIFO (W) that arbitrates for the common data bus.
module alu_exec_unit #(
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            futransmit,
  input  logic [7:0]      operandin,
  input  logic [1:0][7:0] depvalsin,
  input  logic [7:0]      wbsin,
  input  logic [7:0]      flagin,
  input  logic [3:0]      robidin,
  output logic            fubusy,
  input  logic            flush,
  output logic            cdbreq,
  input  logic            cdbgrant,
  output logic [3:0]      cdbrobid,
  output logic [7:0]      cdbval,
  output logic [7:0]      cdbwbs,
  output logic [7:0]      cdbflags
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  localparam logic [7:0] OP_ADD   = 8'd0;
  localparam logic [7:0] OP_SUB   = 8'd1;
  localparam logic [7:0] OP_AND   = 8'd2;
  localparam logic [7:0] OP_OR    = 8'd3;
  localparam logic [7:0] OP_XOR   = 8'd4;
  localparam logic [7:0] OP_SHL   = 8'd5;
  localparam logic [7:0] OP_SHR   = 8'd6;
  localparam logic [7:0] OP_PASSB = 8'd7;

  typedef struct packed {
    logic [3:0] robid;
    logic [7:0] wbs;
    logic [7:0] val;
    logic [7:0] flags;
  } result_t;

  // ALU signals
  logic [7:0] op_a;
  logic [7:0] op_b;
  logic       carry_in;
  logic [8:0] sum9;
  logic [8:0] diff9;
  logic [7:0] alu_res;
  logic       alu_carry;
  logic       alu_illegal;
  result_t    issue_res;

  // Pipeline / FIFO state
  logic          exec_valid;
  result_t       exec_data;
  result_t       mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  // Handshake strobes
  logic issue_ok;
  logic push;
  logic pop;
  result_t head;

  // Only bit0 of flagin is meaningful; upper bits are intentionally dropped.
  logic unused_flag_bits;
  assign unused_flag_bits = ^flagin[7:1];

  assign op_a     = depvalsin[0];
  assign op_b     = depvalsin[1];
  assign carry_in = flagin[0];

  // Combinational ALU: result, carry/borrow and illegal-opcode detection
  always_comb begin
    alu_res     = '0;
    alu_carry   = 1'b0;
    alu_illegal = 1'b0;
    sum9        = {1'b0, op_a} + {1'b0, op_b} + 9'(carry_in);
    diff9       = {1'b0, op_a} - {1'b0, op_b} - 9'(carry_in);
    case (operandin)
      OP_ADD: begin
        alu_res   = sum9[7:0];
        alu_carry = sum9[8];
      end
      OP_SUB: begin
        alu_res   = diff9[7:0];
        alu_carry = diff9[8];
      end
      OP_AND:   alu_res = op_a & op_b;
      OP_OR:    alu_res = op_a | op_b;
      OP_XOR:   alu_res = op_a ^ op_b;
      OP_SHL:   alu_res = op_a << op_b[2:0];
      OP_SHR:   alu_res = op_a >> op_b[2:0];
      OP_PASSB: alu_res = op_b;
      default:  alu_illegal = 1'b1;
    endcase
  end

  // Package ALU outcome with the carried-through tags
  always_comb begin
    issue_res       = '0;
    issue_res.robid = robidin;
    issue_res.wbs   = wbsin;
    issue_res.val   = alu_res;
    issue_res.flags = {4'b0000, alu_illegal, alu_res[7], alu_carry, (alu_res == 8'h00)};
  end

  // Occupancy-based back-pressure, derived from registered state only
  assign fubusy   = (count + CW'(exec_valid)) >= CW'(DEPTH);
  assign cdbreq   = (count != '0);
  assign issue_ok = futransmit & ~fubusy & ~flush;
  assign push     = exec_valid & ~flush;
  assign pop      = cdbgrant & cdbreq & ~flush;

  // Exec-stage valid bit
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      exec_valid <= 1'b0;
    end else begin
      exec_valid <= issue_ok;
    end
  end

  // Exec-stage payload; masked by exec_valid so no reset needed
  always_ff @(posedge clk) begin
    if (issue_ok) begin
      exec_data <= issue_res;
    end
  end

  // Result FIFO storage; masked by count so no reset needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= exec_data;
    end
  end

  // FIFO pointers and occupancy; power-of-two depth gives natural wrap
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // CDB outputs show the FIFO head, forced to zero when empty
  always_comb begin
    head     = mem[rd_ptr];
    cdbrobid = '0;
    cdbval   = '0;
    cdbwbs   = '0;
    cdbflags = '0;
    if (cdbreq) begin
      cdbrobid = head.robid;
      cdbval   = head.val;
      cdbwbs   = head.wbs;
      cdbflags = head.flags;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit (DEPTH = 4).
module tb_alu_exec_unit;

  logic            clk;
  logic            rst;
  logic            futransmit;
  logic [7:0]      operandin;
  logic [1:0][7:0] depvalsin;
  logic [7:0]      wbsin;
  logic [7:0]      flagin;
  logic [3:0]      robidin;
  logic            fubusy;
  logic            flush;
  logic            cdbreq;
  logic            cdbgrant;
  logic [3:0]      cdbrobid;
  logic [7:0]      cdbval;
  logic [7:0]      cdbwbs;
  logic [7:0]      cdbflags;

  int checks;
  int failures;

  alu_exec_unit #(.DEPTH(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .futransmit (futransmit),
    .operandin  (operandin),
    .depvalsin  (depvalsin),
    .wbsin      (wbsin),
    .flagin     (flagin),
    .robidin    (robidin),
    .fubusy     (fubusy),
    .flush      (flush),
    .cdbreq     (cdbreq),
    .cdbgrant   (cdbgrant),
    .cdbrobid   (cdbrobid),
    .cdbval     (cdbval),
    .cdbwbs     (cdbwbs),
    .cdbflags   (cdbflags)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs sample here
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [7:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] fl, input logic [3:0] rob);
    operandin    = op;
    depvalsin[0] = a;
    depvalsin[1] = b;
    flagin       = fl;
    robidin      = rob;
    wbsin        = {4'hC, rob};
  endtask

  // One issue into an empty unit, checked at W-stage output, then popped
  task automatic run_single(input string tag, input logic [7:0] op, input logic [7:0] a,
                            input logic [7:0] b, input logic [7:0] fl, input logic [3:0] rob,
                            input logic [7:0] exp_val, input logic [7:0] exp_flags);
    cdbgrant   = 1'b0;
    drive(op, a, b, fl, rob);
    futransmit = 1'b1;
    tick();
    futransmit = 1'b0;
    check_eq({tag, "_req_e"}, 32'(cdbreq), 32'd0);
    tick();
    check_eq({tag, "_req"},   32'(cdbreq),   32'd1);
    check_eq({tag, "_val"},   32'(cdbval),   32'(exp_val));
    check_eq({tag, "_flags"}, 32'(cdbflags), 32'(exp_flags));
    check_eq({tag, "_robid"}, 32'(cdbrobid), 32'(rob));
    check_eq({tag, "_wbs"},   32'(cdbwbs),   32'({4'hC, rob}));
    cdbgrant = 1'b1;
    tick();
    cdbgrant = 1'b0;
    check_eq({tag, "_popped"}, 32'(cdbreq), 32'd0);
  endtask

  // Four back-to-back PASSB issues (values base..base+3) with no grant;
  // leaves three results buffered and one in exec.
  task automatic fill4(input logic [7:0] base);
    cdbgrant   = 1'b0;
    futransmit = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive(8'd7, 8'h00, base + 8'(i), 8'h00, 4'(i));
      tick();
    end
    futransmit = 1'b0;
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    rst        = 1'b0;
    futransmit = 1'b0;
    flush      = 1'b0;
    cdbgrant   = 1'b0;
    drive(8'd0, 8'h00, 8'h00, 8'h00, 4'd0);

    // Reset state
    #2 rst = 1'b1;
    tick();
    tick();
    check_eq("rst_req",   32'(cdbreq),   32'd0);
    check_eq("rst_busy",  32'(fubusy),   32'd0);
    check_eq("rst_val",   32'(cdbval),   32'd0);
    check_eq("rst_flags", 32'(cdbflags), 32'd0);
    rst = 1'b0;
    tick();
    check_eq("post_rst_req", 32'(cdbreq), 32'd0);

    // ADD 0x7F+0x01 with grant held: 2-cycle latency, popped same cycle
    cdbgrant = 1'b1;
    drive(8'd0, 8'h7F, 8'h01, 8'h00, 4'd3);
    futransmit = 1'b1;
    tick();
    futransmit = 1'b0;
    check_eq("add7f_req_e", 32'(cdbreq), 32'd0);
    tick();
    check_eq("add7f_req",   32'(cdbreq),   32'd1);
    check_eq("add7f_val",   32'(cdbval),   32'h80);
    check_eq("add7f_flags", 32'(cdbflags), 32'h04);
    check_eq("add7f_robid", 32'(cdbrobid), 32'd3);
    tick();
    check_eq("add7f_popped", 32'(cdbreq), 32'd0);
    cdbgrant = 1'b0;

    // Directed ALU vectors
    run_single("sub_borrow", 8'd1, 8'h00, 8'h01, 8'h01, 4'd1, 8'hFE, 8'h06);
    run_single("add_wrap",   8'd0, 8'hFF, 8'h01, 8'h00, 4'd2, 8'h00, 8'h03);
    run_single("add_cin",    8'd0, 8'h10, 8'h20, 8'hFF, 4'd4, 8'h31, 8'h00);
    run_single("add_nocin",  8'd0, 8'h10, 8'h20, 8'hFE, 4'd5, 8'h30, 8'h00);
    run_single("and",        8'd2, 8'hF0, 8'h3C, 8'h01, 4'd6, 8'h30, 8'h00);
    run_single("or",         8'd3, 8'h80, 8'h01, 8'h00, 4'd8, 8'h81, 8'h04);
    run_single("xor_zero",   8'd4, 8'hAA, 8'hAA, 8'h00, 4'd9, 8'h00, 8'h01);
    run_single("shl",        8'd5, 8'h81, 8'h09, 8'h00, 4'd10, 8'h02, 8'h00);
    run_single("shr",        8'd6, 8'h80, 8'h0F, 8'h00, 4'd11, 8'h01, 8'h00);
    run_single("passb",      8'd7, 8'h11, 8'h9C, 8'h00, 4'd12, 8'h9C, 8'h04);
    run_single("illegal9",   8'h09, 8'h55, 8'h66, 8'h01, 4'd7, 8'h00, 8'h09);
    run_single("illegalff",  8'hFF, 8'h01, 8'h01, 8'h00, 4'd13, 8'h00, 8'h09);

    // Issue every cycle with no grant: only DEPTH accepted
    cdbgrant   = 1'b0;
    futransmit = 1'b1;
    for (int i = 0; i < 7; i++) begin
      drive(8'd7, 8'h00, 8'h40 + 8'(i), 8'h00, 4'(i));
      tick();
      check_eq($sformatf("bp_busy%0d", i), 32'(fubusy), (i >= 3) ? 32'd1 : 32'd0);
    end
    check_eq("bp_head0", 32'(cdbval), 32'h40);
    drive(8'd7, 8'h00, 8'h99, 8'h00, 4'd15);
    cdbgrant = 1'b1;
    tick();
    cdbgrant   = 1'b0;
    futransmit = 1'b0;
    check_eq("bp_busy_drop", 32'(fubusy), 32'd0);
    cdbgrant = 1'b1;
    for (int i = 1; i < 4; i++) begin
      check_eq($sformatf("bp_drain%0d", i), 32'(cdbval), 32'h40 + 32'(i));
      tick();
    end
    check_eq("bp_empty", 32'(cdbreq), 32'd0);
    cdbgrant = 1'b0;

    // Full buffer with simultaneous pop and push, streaming across pointer wrap
    fill4(8'h10);
    check_eq("wrap_busy_full", 32'(fubusy), 32'd1);
    check_eq("wrap_head0", 32'(cdbval), 32'h10);
    cdbgrant = 1'b1;
    tick();
    check_eq("wrap_busy_after", 32'(fubusy), 32'd0);
    check_eq("wrap_head1", 32'(cdbval), 32'h11);
    futransmit = 1'b1;
    for (int i = 0; i < 8; i++) begin
      drive(8'd7, 8'h00, 8'h20 + 8'(i), 8'h00, 4'(i));
      tick();
      check_eq($sformatf("wrap_seq%0d", i), 32'(cdbval),
               (i < 2) ? (32'h12 + 32'(i)) : (32'h20 + 32'(i - 2)));
      check_eq($sformatf("wrap_busy%0d", i), 32'(fubusy), 32'd0);
    end
    futransmit = 1'b0;
    tick();
    check_eq("wrap_tail0", 32'(cdbval), 32'h26);
    tick();
    check_eq("wrap_tail1", 32'(cdbval), 32'h27);
    tick();
    check_eq("wrap_empty", 32'(cdbreq), 32'd0);
    cdbgrant = 1'b0;

    // Flush with three buffered and one in exec, concurrent issue and grant
    fill4(8'h30);
    check_eq("flush_pre_req", 32'(cdbreq), 32'd1);
    flush      = 1'b1;
    futransmit = 1'b1;
    cdbgrant   = 1'b1;
    drive(8'd7, 8'h00, 8'h77, 8'h00, 4'd1);
    tick();
    flush      = 1'b0;
    futransmit = 1'b0;
    cdbgrant   = 1'b0;
    check_eq("flush_req",  32'(cdbreq), 32'd0);
    check_eq("flush_busy", 32'(fubusy), 32'd0);
    check_eq("flush_val",  32'(cdbval), 32'd0);
    tick();
    check_eq("flush_no_issue", 32'(cdbreq), 32'd0);
    run_single("post_flush", 8'd0, 8'h01, 8'h02, 8'h00, 4'd14, 8'h03, 8'h00);

    // Asynchronous reset mid-stream
    fill4(8'h50);
    tick();
    check_eq("arst_pre_req", 32'(cdbreq), 32'd1);
    check_eq("arst_pre_val", 32'(cdbval), 32'h50);
    #2 rst = 1'b1;
    #1;
    check_eq("arst_req",   32'(cdbreq),   32'd0);
    check_eq("arst_busy",  32'(fubusy),   32'd0);
    check_eq("arst_val",   32'(cdbval),   32'd0);
    check_eq("arst_robid", 32'(cdbrobid), 32'd0);
    check_eq("arst_flags", 32'(cdbflags), 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();
    check_eq("arst_rel_req", 32'(cdbreq), 32'd0);
    tick();
    check_eq("arst_rel_req2",  32'(cdbreq), 32'd0);
    check_eq("arst_rel_busy",  32'(fubusy), 32'd0);
    run_single("post_arst", 8'd1, 8'h05, 8'h03, 8'h00, 4'd2, 8'h02, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
